// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-detecting, fixed-priority (lowest index wins) interrupt controller
// driving the intr/int_ack handshake, with one interrupt in service until eoi.
module intr_ctrl #(
    parameter int          NUM_SRC    = 8,
    parameter int          ID_W       = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               intr,
    output logic [ID_W-1:0]    vec_id,
    output logic [31:0]        vec_addr,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);
    typedef enum logic [1:0] {IDLE, REQ, ACK_LOW, SERVICE} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] edge_v;
    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               accept;

    assign edge_v  = irq_in & ~irq_prev;
    assign req_vec = pending & irq_mask;
    // An ack that arrives after the request has vanished accepts nothing.
    assign accept  = state == REQ && int_ack && |req_vec;
    assign clr     = accept ? NUM_SRC'(1) << winner : '0;

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (req_vec[i]) winner = ID_W'(i);
    end

    always_ff @(posedge clk) begin
        irq_prev <= irq_in;
        if (rst) begin
            state      <= IDLE;
            intr       <= 1'b0;
            vec_id     <= '0;
            vec_addr   <= VEC_BASE;
            pending    <= '0;
            in_service <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | edge_v;
            case (state)
                IDLE: if (|req_vec) begin
                    state <= REQ;
                    intr  <= 1'b1;
                end
                REQ: if (accept) begin
                    vec_id     <= winner;
                    vec_addr   <= VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);
                    in_service <= 1'b1;
                    intr       <= 1'b0;
                    state      <= ACK_LOW;
                end else if (!(|req_vec)) begin
                    intr  <= 1'b0;
                    state <= IDLE;
                end
                ACK_LOW: if (!int_ack) state <= SERVICE;
                SERVICE: if (eoi) begin
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed plus randomized checks of intr_ctrl against a behavioural model,
// with accepted vectors checked through a scoreboard queue.
module tb_intr_ctrl;
    localparam int          NS     = 8;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          STRIDE = 8;

    logic        clk = 0;
    logic        rst = 1;
    logic [7:0]  irq_in = 8'h01;
    logic [7:0]  irq_mask = 8'hFF;
    logic        int_ack = 0;
    logic        eoi = 0;
    logic        intr;
    logic [2:0]  vec_id;
    logic [31:0] vec_addr;
    logic [7:0]  pending;
    logic        in_service;

    intr_ctrl dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .int_ack(int_ack),
        .eoi(eoi), .intr(intr), .vec_id(vec_id), .vec_addr(vec_addr), .pending(pending),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit checking = 0;

    // Reference model: phase 0 quiet, 1 requesting, 2 waiting for ack release, 3 servicing.
    int          m_phase;
    logic        m_intr, m_insvc;
    logic [2:0]  m_id;
    logic [31:0] m_addr;
    bit          m_pend [NS];
    bit          m_prev [NS];
    logic [34:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_request();
        for (int i = 0; i < NS; i++)
            if (m_pend[i] && irq_mask[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] pend_bits();
        logic [7:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_step();
        int w;
        bit rise [NS];
        if (rst) begin
            m_phase = 0; m_intr = 0; m_insvc = 0; m_id = 0; m_addr = BASE;
            for (int i = 0; i < NS; i++) begin m_pend[i] = 0; m_prev[i] = irq_in[i]; end
            return;
        end
        for (int i = 0; i < NS; i++) begin
            rise[i] = irq_in[i] && !m_prev[i];
            m_prev[i] = irq_in[i];
        end
        w = lowest_request();
        if (m_phase == 0 && w >= 0) begin
            m_phase = 1; m_intr = 1;
        end else if (m_phase == 1 && int_ack && w >= 0) begin
            m_id = 3'(w);
            m_addr = BASE + w * STRIDE;
            m_pend[w] = 0;
            m_insvc = 1; m_intr = 0; m_phase = 2;
            exp_q.push_back({m_id, m_addr});
        end else if (m_phase == 1 && w < 0) begin
            m_phase = 0; m_intr = 0;
        end else if (m_phase == 2 && !int_ack) begin
            m_phase = 3;
        end else if (m_phase == 3 && eoi) begin
            m_insvc = 0; m_phase = 0;
        end
        for (int i = 0; i < NS; i++) if (rise[i]) m_pend[i] = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: per-cycle state compare, and a scoreboard pop on every new acceptance.
    logic last_insvc = 0;
    always @(negedge clk) if (checking) begin
        logic [34:0] e;
        chk("intr", 32'(intr), 32'(m_intr));
        chk("pending", 32'(pending), 32'(pend_bits()));
        chk("in_service", 32'(in_service), 32'(m_insvc));
        chk("vec_id", 32'(vec_id), 32'(m_id));
        chk("vec_addr", vec_addr, m_addr);
        if (in_service && !last_insvc) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL accept_unexpected: got id %0d with no expected acceptance", vec_id);
            end else begin
                e = exp_q.pop_front();
                chk("sb_vec_id", 32'(vec_id), 32'(e[34:32]));
                chk("sb_vec_addr", vec_addr, e[31:0]);
            end
        end
        last_insvc = in_service;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v; tick();
        irq_in = 8'h00; tick();
    endtask

    task automatic accept_and_retire();
        int_ack = 1; tick();
        int_ack = 0; tick();
        eoi = 1; tick();
        eoi = 0;
    endtask

    initial begin
        tick(2);
        checking = 1;
        rst = 0;
        tick(10);
        chk("held_line_pending", 32'(pending), 32'h0);
        chk("held_line_intr", 32'(intr), 32'h0);
        irq_in = 8'h00; tick();
        irq_in = 8'h01; tick();
        chk("rearm_pending", 32'(pending), 32'h01);
        tick();
        chk("rearm_intr", 32'(intr), 32'h1);
        irq_in = 8'h00;
        accept_and_retire();
        tick(2);

        pulse(8'h24);
        chk("dual_intr", 32'(intr), 32'h1);
        int_ack = 1; tick(); int_ack = 0;
        chk("dual_id2", 32'(vec_id), 32'd2);
        chk("dual_addr2", vec_addr, 32'h0000_0110);
        chk("dual_pend", 32'(pending), 32'h20);
        chk("dual_insvc", 32'(in_service), 32'h1);
        tick(); eoi = 1; tick(); eoi = 0; tick();
        chk("dual_reintr", 32'(intr), 32'h1);
        int_ack = 1; tick(); int_ack = 0;
        chk("dual_id5", 32'(vec_id), 32'd5);
        chk("dual_addr5", vec_addr, 32'h0000_0128);
        chk("dual_pend0", 32'(pending), 32'h00);
        tick(); eoi = 1; tick(); eoi = 0; tick();

        pulse(8'h40);
        irq_in = 8'h02; tick(); irq_in = 8'h00;
        int_ack = 1; tick(); int_ack = 0;
        chk("preempt_id", 32'(vec_id), 32'd1);
        chk("preempt_pend6", 32'(pending[6]), 32'h1);
        tick(); eoi = 1; tick(); eoi = 0; tick();
        accept_and_retire();
        tick();

        irq_mask = 8'h00;
        pulse(8'h08); tick();
        chk("masked_pend", 32'(pending), 32'h08);
        chk("masked_intr", 32'(intr), 32'h0);
        irq_mask = 8'h08; tick();
        chk("unmask_intr", 32'(intr), 32'h1);
        irq_mask = 8'h00; tick();
        chk("remask_intr", 32'(intr), 32'h0);
        chk("remask_pend", 32'(pending), 32'h08);
        irq_mask = 8'hFF; tick();
        accept_and_retire();
        tick();

        pulse(8'h03);
        int_ack = 1; tick();
        eoi = 1; tick(3);
        int_ack = 0; eoi = 0;
        chk("held_ack_id", 32'(vec_id), 32'd0);
        chk("held_ack_pend", 32'(pending), 32'h02);
        chk("held_ack_insvc", 32'(in_service), 32'h1);
        tick();
        chk("ack_low_eoi_ignored", 32'(in_service), 32'h1);
        eoi = 1; tick(); eoi = 0;
        chk("eoi_in_service", 32'(in_service), 32'h0);
        tick();
        accept_and_retire();
        tick();

        pulse(8'h01);
        int_ack = 1; tick(); int_ack = 0; tick();
        pulse(8'h0C);
        chk("svc_pend", 32'(pending), 32'h0C);
        rst = 1; tick(); rst = 0;
        chk("rst_insvc", 32'(in_service), 32'h0);
        chk("rst_pend", 32'(pending), 32'h00);
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_addr", vec_addr, 32'h0000_0100);

        for (int c = 0; c < 3000; c++) begin
            irq_in  = 8'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) irq_mask = 8'($urandom);
            int_ack = $urandom_range(0, 9) < 3;
            eoi     = $urandom_range(0, 9) < 2;
            rst     = $urandom_range(0, 299) == 0;
            tick();
        end
        rst = 0; int_ack = 0; eoi = 0; irq_in = 8'h00;
        tick(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
